// File: rtl/module_demultiplexer_2_output_8_bit_seq.sv
// ---------------------------------------------------------------------------
// module_demultiplexer_2_output_8_bit_seq
//
// Purpose:
//   Collects a pair of time-multiplexed bytes arriving on in_data. The
//   address=0 byte is registered onto out_0 and the address=1 byte onto
//   out_1. A complete pair is presented with out_valid and held until the
//   consumer acknowledges it with out_ack. A byte that arrives out of order
//   raises a one-cycle seq_error pulse. pair_count counts acknowledged
//   pairs and wraps modulo 256.
//
// Handshakes:
//   Input side : a byte is taken on a rising edge where in_valid=1 and
//                in_ready=1. in_ready depends only on the current state.
//                While in_ready=0, in_valid, address and in_data are ignored.
//   Output side: out_valid=1 means out_0/out_1 hold a complete pair. The pair
//                is retired on a rising edge where out_valid=1 and out_ack=1.
//                When out_valid=0, out_ack is ignored.
//
// Ports:
//   clock       in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   in_valid    in   in_data/address offered this cycle
//   address     in   destination select (0 -> out_0, 1 -> out_1)
//   in_data     in   DATA_WIDTH byte
//   in_ready    out  block can accept a byte this cycle (combinational)
//   out_0       out  registered byte for destination 0
//   out_1       out  registered byte for destination 1
//   out_valid   out  complete pair held on out_0/out_1
//   out_ack     in   consumer has taken the pair
//   seq_error   out  one-cycle pulse on an out-of-order byte
//   pair_count  out  pairs acknowledged since reset (wraps)
// ---------------------------------------------------------------------------
module module_demultiplexer_2_output_8_bit_seq #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic                  address,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_0,
  output logic [DATA_WIDTH-1:0] out_1,
  output logic                  out_valid,
  input  logic                  out_ack,
  output logic                  seq_error,
  output logic [7:0]            pair_count
);

  localparam logic [1:0] S_WAIT_0 = 2'd0;
  localparam logic [1:0] S_WAIT_1 = 2'd1;
  localparam logic [1:0] S_FULL   = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic [DATA_WIDTH-1:0] r_out_0;
  logic [DATA_WIDTH-1:0] r_out_1;
  logic                  r_out_valid;
  logic                  r_seq_error;
  logic [7:0]            r_pair_count;

  logic                  w_accept;
  logic                  w_load_0;
  logic                  w_load_1;
  logic                  w_seq_err;
  logic                  w_retire;

  // Ready in both collecting states; the unused encoding also counts as
  // "not full" so a corrupted state can still drain back to WAIT_0.
  assign in_ready = (r_state != S_FULL);
  assign w_accept = in_valid && in_ready;
  assign w_retire = (r_state == S_FULL) && out_ack;

  always_comb begin
    w_next_state = r_state;
    w_load_0     = 1'b0;
    w_load_1     = 1'b0;
    w_seq_err    = 1'b0;
    case (r_state)
      S_WAIT_0: begin
        if (w_accept) begin
          if (!address) begin
            w_load_0     = 1'b1;
            w_next_state = S_WAIT_1;
          end else begin
            // Second half of a pair with no first half: drop it.
            w_seq_err = 1'b1;
          end
        end
      end
      S_WAIT_1: begin
        if (w_accept) begin
          if (address) begin
            w_load_1     = 1'b1;
            w_next_state = S_FULL;
          end else begin
            // A new first half restarts the pair.
            w_load_0  = 1'b1;
            w_seq_err = 1'b1;
          end
        end
      end
      S_FULL: begin
        if (w_retire) begin
          w_next_state = S_WAIT_0;
        end
      end
      default: begin
        w_next_state = S_WAIT_0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_WAIT_0;
      r_out_0      <= '0;
      r_out_1      <= '0;
      r_out_valid  <= 1'b0;
      r_seq_error  <= 1'b0;
      r_pair_count <= 8'd0;
    end else begin
      r_state     <= w_next_state;
      // out_valid is registered alongside the state so it mirrors FULL.
      r_out_valid <= (w_next_state == S_FULL);
      r_seq_error <= w_seq_err;
      if (w_load_0) begin
        r_out_0 <= in_data;
      end
      if (w_load_1) begin
        r_out_1 <= in_data;
      end
      if (w_retire) begin
        r_pair_count <= r_pair_count + 8'd1;
      end
    end
  end

  assign out_0      = r_out_0;
  assign out_1      = r_out_1;
  assign out_valid  = r_out_valid;
  assign seq_error  = r_seq_error;
  assign pair_count = r_pair_count;

endmodule

// File: tb/tb_module_demultiplexer_2_output_8_bit_seq.sv
module tb_module_demultiplexer_2_output_8_bit_seq;

  localparam int W = 8;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         address = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ack = 1'b0;
  logic         in_ready;
  logic [W-1:0] out_0;
  logic [W-1:0] out_1;
  logic         out_valid;
  logic         seq_error;
  logic [7:0]   pair_count;

  always #5 clock = ~clock;

  module_demultiplexer_2_output_8_bit_seq #(.DATA_WIDTH(W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .address    (address),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_0      (out_0),
    .out_1      (out_1),
    .out_valid  (out_valid),
    .out_ack    (out_ack),
    .seq_error  (seq_error),
    .pair_count (pair_count)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // -------------------------------------------------------------------------
  // Behavioural model: "holding a first byte?", "holding a complete pair?",
  // the two held bytes, a pair tally and whether the last clock saw an
  // out-of-order byte.
  // -------------------------------------------------------------------------
  logic [W-1:0] m_out0 = '0;
  logic [W-1:0] m_out1 = '0;
  bit           m_have_first = 1'b0;
  bit           m_full = 1'b0;
  int           m_pairs = 0;
  bit           m_err = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process: updates the model at each edge (or on reset),
  // then checks every output 1 time unit later.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_out0 = '0; m_out1 = '0;
      m_have_first = 0; m_full = 0; m_pairs = 0; m_err = 0;
    end else begin
      bit was_full;
      was_full = m_full;
      m_err = 0;
      if (!was_full && in_valid) begin
        if (address == 1'b0) begin
          m_out0 = in_data;
          if (m_have_first) m_err = 1;
          m_have_first = 1;
        end else if (m_have_first) begin
          m_out1 = in_data;
          m_have_first = 0;
          m_full = 1;
        end else begin
          m_err = 1;
        end
      end
      if (was_full && out_ack) begin
        m_full = 0;
        m_pairs = (m_pairs + 1) % 256;
      end
    end
    #1;
    if (chk_en) begin
      cmp("model out_0", 32'(out_0), 32'(m_out0));
      cmp("model out_1", 32'(out_1), 32'(m_out1));
      cmp("model out_valid", 32'(out_valid), 32'(m_full));
      cmp("model in_ready", 32'(in_ready), 32'(!m_full));
      cmp("model seq_error", 32'(seq_error), 32'(m_err));
      cmp("model pair_count", 32'(pair_count), 32'(m_pairs));
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks (inputs change on the falling edge)
  // -------------------------------------------------------------------------
  task automatic send(input logic a, input logic [W-1:0] d);
    @(negedge clock);
    in_valid = 1'b1; address = a; in_data = d;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic ack();
    @(negedge clock);
    out_ack = 1'b1;
    @(negedge clock);
    out_ack = 1'b0;
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  // -------------------------------------------------------------------------
  // Directed scenarios with hand-computed literals
  // -------------------------------------------------------------------------
  initial begin
    repeat (3) @(negedge clock);
    chk_en = 1'b1;
    // Reset state
    cmp("reset in_ready", 32'(in_ready), 32'd1);
    cmp("reset out_valid", 32'(out_valid), 32'd0);
    cmp("reset pair_count", 32'(pair_count), 32'd0);
    reset_n = 1'b1;

    // Normal pair
    send(1'b0, 8'h12);
    cmp("pair out_valid early", 32'(out_valid), 32'd0);
    send(1'b1, 8'h34);
    cmp("pair out_0", 32'(out_0), 32'h12);
    cmp("pair out_1", 32'(out_1), 32'h34);
    cmp("pair out_valid", 32'(out_valid), 32'd1);
    cmp("pair in_ready", 32'(in_ready), 32'd0);

    // Hold in FULL while in_valid is driven with 0xFF
    @(negedge clock);
    in_valid = 1'b1; in_data = 8'hFF; address = 1'b0;
    repeat (5) @(negedge clock);
    in_valid = 1'b0;
    cmp("hold out_0", 32'(out_0), 32'h12);
    cmp("hold out_1", 32'(out_1), 32'h34);
    cmp("hold out_valid", 32'(out_valid), 32'd1);
    ack();
    cmp("ack pair_count", 32'(pair_count), 32'd1);
    cmp("ack out_valid", 32'(out_valid), 32'd0);
    cmp("ack in_ready", 32'(in_ready), 32'd1);
    cmp("ack out_0 kept", 32'(out_0), 32'h12);

    // out_ack while collecting is ignored
    ack();
    cmp("idle ack pair_count", 32'(pair_count), 32'd1);

    // Wrong first address
    send(1'b1, 8'hAA);
    cmp("wrong addr seq_error", 32'(seq_error), 32'd1);
    cmp("wrong addr out_1", 32'(out_1), 32'h34);
    @(negedge clock);
    cmp("wrong addr pulse end", 32'(seq_error), 32'd0);
    cmp("wrong addr in_ready", 32'(in_ready), 32'd1);

    // Pair restart
    send(1'b0, 8'h01);
    cmp("restart no err", 32'(seq_error), 32'd0);
    send(1'b0, 8'h02);
    cmp("restart seq_error", 32'(seq_error), 32'd1);
    send(1'b1, 8'h03);
    cmp("restart err cleared", 32'(seq_error), 32'd0);
    cmp("restart out_0", 32'(out_0), 32'h02);
    cmp("restart out_1", 32'(out_1), 32'h03);
    cmp("restart out_valid", 32'(out_valid), 32'd1);
    ack();
    cmp("restart pair_count", 32'(pair_count), 32'd2);

    // Counter wrap: 254 more pairs brings the count from 2 through 255 to 0
    for (int i = 0; i < 254; i++) begin
      send(1'b0, 8'(i));
      send(1'b1, 8'(~i));
      ack();
    end
    cmp("wrap pair_count", 32'(pair_count), 32'd0);
    cmp("wrap out_1", 32'(out_1), 32'(8'(~253)));

    // Reset mid-pair
    send(1'b0, 8'h5A);
    #2 reset_n = 1'b0;
    #1 cmp("midpair reset out_0", 32'(out_0), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Reset in FULL, asserted between clock edges
    send(1'b0, 8'hC3);
    send(1'b1, 8'h3C);
    ack();
    send(1'b0, 8'h77);
    send(1'b1, 8'h88);
    cmp("pre-reset pair_count", 32'(pair_count), 32'd1);
    cmp("pre-reset out_valid", 32'(out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    cmp("async reset out_valid", 32'(out_valid), 32'd0);
    cmp("async reset out_0", 32'(out_0), 32'd0);
    cmp("async reset out_1", 32'(out_1), 32'd0);
    cmp("async reset pair_count", 32'(pair_count), 32'd0);
    cmp("async reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    send(1'b0, 8'h10);
    send(1'b1, 8'h20);
    cmp("post reset out_0", 32'(out_0), 32'h10);
    cmp("post reset out_valid", 32'(out_valid), 32'd1);
    ack();
    cmp("post reset pair_count", 32'(pair_count), 32'd1);

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
